// File: rtl/display_tx_scheduler.sv
// Character scheduler for the text display: buffers CPU/aux characters in a shared FIFO,
// arbitrates the two sources round-robin and sequences writes and clear-screen against the display.
module display_tx_scheduler #(
  parameter int FIFO_DEPTH  = 16,
  parameter int CLR_FRAMES  = 1,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic       cpu_clken,
  input  logic       pixel_clken,
  input  logic       cpu_req,
  input  logic [7:0] cpu_data,
  output logic       cpu_busy,
  input  logic       aux_req,
  input  logic [7:0] aux_data,
  output logic       aux_ack,
  input  logic       clr_req,
  input  logic       vga_v_sync,
  input  logic       disp_ready,
  output logic       disp_address,
  output logic       disp_w_en,
  output logic [7:0] disp_din,
  output logic       disp_clr_screen
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(CLR_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RDY, CLEAR} state_t;

  state_t        state_q, state_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic          hold_vld_q, hold_vld_d;
  logic [7:0]    hold_data_q, hold_data_d;
  logic          rr_aux_q, rr_aux_d;
  logic [7:0]    to_cnt_q, to_cnt_d;
  logic [FW-1:0] frm_cnt_q, frm_cnt_d;
  logic          vs_q, vs_d;
  logic [7:0]    disp_din_q, disp_din_d;

  logic       full, empty, ack, vs_fall, frames_done, timed_out;
  logic       pop, flush, can_push, cpu_pend, grant_cpu, grant_aux, push;
  logic [7:0] push_data;

  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign ack         = pixel_clken & cpu_clken & ~disp_ready;
  assign vs_fall     = vs_q & ~vga_v_sync;
  assign frames_done = vs_fall && (frm_cnt_q == FW'(CLR_FRAMES - 1));
  assign timed_out   = (to_cnt_q == 8'(ACK_TIMEOUT - 1));

  // State register
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a clear request overrides everything, including a write in flight
  always_comb begin
    state_d = state_q;
    if (clr_req) begin
      state_d = CLEAR;
    end else begin
      case (state_q)
        IDLE:     if (!empty && pixel_clken && disp_ready) state_d = ISSUE;
        ISSUE:    if (ack) state_d = WAIT_RDY;
                  else if (timed_out) state_d = IDLE;
        WAIT_RDY: if (pixel_clken && disp_ready) state_d = IDLE;
        CLEAR:    if (frames_done) state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Moore outputs
  always_comb begin
    disp_address    = 1'b1;
    disp_w_en       = 1'b0;
    disp_clr_screen = 1'b0;
    case (state_q)
      ISSUE:   begin disp_address = 1'b0; disp_w_en = 1'b1; end
      CLEAR:   disp_clr_screen = 1'b1;
      default: ;
    endcase
  end

  assign pop   = (state_q == IDLE) && (state_d == ISSUE);
  assign flush = (state_q == CLEAR) && (state_d == IDLE);

  // Push arbitration: a held CPU strobe counts as a pending CPU request.
  // The round-robin pointer only moves when both sources actually contend.
  always_comb begin
    cpu_pend  = hold_vld_q | cpu_req;
    can_push  = ~full | pop;
    grant_cpu = can_push & cpu_pend & (~aux_req | ~rr_aux_q);
    grant_aux = can_push & aux_req & (~cpu_pend | rr_aux_q);
    push      = grant_cpu | grant_aux;
    push_data = grant_aux ? aux_data : (hold_vld_q ? hold_data_q : cpu_data);
    rr_aux_d  = (cpu_pend & aux_req & can_push) ? ~rr_aux_q : rr_aux_q;
  end

  // Hold register: catches a CPU strobe that lost arbitration or met a full FIFO
  always_comb begin
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    if (hold_vld_q) begin
      if (grant_cpu) begin
        hold_vld_d  = cpu_req;
        hold_data_d = cpu_data;
      end
    end else if (cpu_req && !grant_cpu) begin
      hold_vld_d  = 1'b1;
      hold_data_d = cpu_data;
    end
    if (flush) hold_vld_d = 1'b0;
  end

  always_comb begin
    wr_ptr_d   = flush ? '0 : (push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q);
    rd_ptr_d   = flush ? '0 : (pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q);
    disp_din_d = pop ? mem_q[rd_ptr_q[AW-1:0]] : disp_din_q;
    to_cnt_d   = ((state_q == ISSUE) && (state_d == ISSUE)) ? to_cnt_q + 8'd1 : 8'd0;
    vs_d       = vga_v_sync;
    frm_cnt_d  = frm_cnt_q;
    if (clr_req || state_q != CLEAR) frm_cnt_d = '0;
    else if (vs_fall)                frm_cnt_d = frm_cnt_q + FW'(1);
  end

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      hold_vld_q <= 1'b0;
      rr_aux_q   <= 1'b0;
      to_cnt_q   <= 8'd0;
      frm_cnt_q  <= '0;
      vs_q       <= 1'b1;
      disp_din_q <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      hold_vld_q <= hold_vld_d;
      rr_aux_q   <= rr_aux_d;
      to_cnt_q   <= to_cnt_d;
      frm_cnt_q  <= frm_cnt_d;
      vs_q       <= vs_d;
      disp_din_q <= disp_din_d;
    end
  end

  // Character storage carries no reset; pointers define validity
  always_ff @(posedge sys_clock) begin
    hold_data_q <= hold_data_d;
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign disp_din = disp_din_q;
  assign aux_ack  = grant_aux & ~reset;
  assign cpu_busy = full | hold_vld_q | (state_q == CLEAR);

endmodule
